// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 window capture block: FSM state codes,
// pixel mode encodings and the decimation counter step.
package ov7670_pkg;

  typedef enum logic [3:0] {
    OCIOSO        = 4'd0,
    ESPERA_VS     = 4'd1,
    INICIO_QUADRO = 4'd2,
    CAPTURA       = 4'd3,
    FIM           = 4'd4
  } estado_t;

  localparam logic MODO_RGB565 = 1'b0;
  localparam logic MODO_CINZA  = 1'b1;

  // Decimation phase counter: wraps to zero after the last phase.
  function automatic logic [1:0] proximo_dec(input logic [1:0] atual, input logic [1:0] ultimo);
    if (atual == ultimo) begin
      return 2'd0;
    end else begin
      return atual + 2'd1;
    end
  endfunction

endpackage

// File: rtl/sincronizador_ov7670.sv
// Two-flop synchronizers for the camera pins into the system clock domain,
// plus edge pulses derived from a third (history) stage.
module sincronizador_ov7670 (
  input  logic       clock,
  input  logic       reset,
  input  logic       vsync_i,
  input  logic       href_i,
  input  logic       pclk_i,
  input  logic [7:0] d_i,
  output logic       vsync_o,
  output logic       href_o,
  output logic [7:0] d_o,
  output logic       pclk_sobe_o,
  output logic       href_desce_o,
  output logic       vsync_sobe_o,
  output logic       vsync_desce_o
);

  // Packed as {vsync, href, pclk, d[7:0]}; D shares the PCLK delay so the byte lines up with its edge.
  logic [10:0] est1_q, est1_d;
  logic [10:0] est2_q, est2_d;
  logic [2:0]  ant_q, ant_d;

  // Next values of the synchronizer chain.
  always_comb begin
    est1_d = {vsync_i, href_i, pclk_i, d_i};
    est2_d = est1_q;
    ant_d  = est2_q[10:8];
  end

  // Synchronizer and history registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      est1_q <= 11'd0;
      est2_q <= 11'd0;
      ant_q  <= 3'd0;
    end else begin
      est1_q <= est1_d;
      est2_q <= est2_d;
      ant_q  <= ant_d;
    end
  end

  assign vsync_o       = est2_q[10];
  assign href_o        = est2_q[9];
  assign d_o           = est2_q[7:0];
  assign pclk_sobe_o   = est2_q[8] & ~ant_q[0];
  assign href_desce_o  = ~est2_q[9] & ant_q[1];
  assign vsync_sobe_o  = est2_q[10] & ~ant_q[2];
  assign vsync_desce_o = ~est2_q[10] & ant_q[2];

endmodule

// File: rtl/captura_janela_ov7670.sv
// Captures a decimated window of one OV7670 frame and emits row-major
// write strobes; FSM and all frame counters live here.
module captura_janela_ov7670
  import ov7670_pkg::*;
#(
  parameter int LINES   = 120,
  parameter int COLUMNS = 160,
  parameter int DECIM   = 2,
  parameter int S_ADDR  = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              modo,
  input  logic [9:0]        lin_ini,
  input  logic [9:0]        col_ini,
  input  logic              VSYNC,
  input  logic              HREF,
  input  logic              PCLK,
  input  logic [7:0]        D,
  output logic              we,
  output logic [S_ADDR-1:0] endereco,
  output logic [15:0]       dado,
  output logic              ocupado,
  output logic              pronto,
  output logic              incompleto,
  output logic [3:0]        db_estado
);

  localparam int CW = $clog2(COLUMNS + 1);
  localparam int LW = $clog2(LINES + 1);
  localparam int AW = S_ADDR + 1;
  localparam logic [AW-1:0] TOTAL_A   = AW'(LINES * COLUMNS);
  localparam logic [AW-1:0] UM_A      = AW'(1);
  localparam logic [CW-1:0] COLUMNS_C = CW'(COLUMNS);
  localparam logic [CW-1:0] UM_C      = CW'(1);
  localparam logic [LW-1:0] LINES_L   = LW'(LINES);
  localparam logic [LW-1:0] UM_L      = LW'(1);
  localparam logic [1:0]    DEC_ULT   = 2'(DECIM - 1);

  logic       vsync_s, href_s, pclk_sobe, href_desce, vsync_sobe, vsync_desce;
  logic [7:0] d_s;

  sincronizador_ov7670 u_sinc (
    .clock         (clock),
    .reset         (reset),
    .vsync_i       (VSYNC),
    .href_i        (HREF),
    .pclk_i        (PCLK),
    .d_i           (D),
    .vsync_o       (vsync_s),
    .href_o        (href_s),
    .d_o           (d_s),
    .pclk_sobe_o   (pclk_sobe),
    .href_desce_o  (href_desce),
    .vsync_sobe_o  (vsync_sobe),
    .vsync_desce_o (vsync_desce)
  );

  estado_t           estado_q, estado_d;
  logic              iniciar_ant_q, iniciar_ant_d;
  logic              modo_q, modo_d;
  logic [9:0]        lin_ini_q, lin_ini_d, col_ini_q, col_ini_d;
  logic              incompleto_q, incompleto_d;
  logic              fase_q, fase_d;
  logic [7:0]        byte0_q, byte0_d;
  logic [9:0]        col_q, col_d, lin_q, lin_d;
  logic [1:0]        col_dec_q, col_dec_d, lin_dec_q, lin_dec_d;
  logic [CW-1:0]     col_arm_q, col_arm_d;
  logic [LW-1:0]     lin_arm_q, lin_arm_d;
  logic [AW-1:0]     cont_q, cont_d;
  logic              pix_ok_q, pix_ok_d;
  logic [15:0]       pix_q, pix_d;
  logic              we_q, we_d;
  logic [S_ADDR-1:0] end_q, end_d;
  logic [15:0]       dado_q, dado_d;
  logic              ocupado_q, ocupado_d;
  logic              pronto_q, pronto_d;
  logic              linha_sel, coluna_sel;

  // FSM next state, window selection and the two-stage store pipeline.
  always_comb begin
    estado_d      = estado_q;
    iniciar_ant_d = iniciar;
    modo_d        = modo_q;
    lin_ini_d     = lin_ini_q;
    col_ini_d     = col_ini_q;
    incompleto_d  = incompleto_q;
    fase_d        = fase_q;
    byte0_d       = byte0_q;
    col_d         = col_q;
    lin_d         = lin_q;
    col_dec_d     = col_dec_q;
    lin_dec_d     = lin_dec_q;
    col_arm_d     = col_arm_q;
    lin_arm_d     = lin_arm_q;
    cont_d        = cont_q;
    pix_ok_d      = 1'b0;
    pix_d         = pix_q;
    we_d          = 1'b0;
    end_d         = end_q;
    dado_d        = dado_q;
    linha_sel     = (lin_q >= lin_ini_q) && (lin_dec_q == 2'd0) && (lin_arm_q < LINES_L);
    coluna_sel    = (col_q >= col_ini_q) && (col_dec_q == 2'd0) && (col_arm_q < COLUMNS_C);

    case (estado_q)
      OCIOSO: begin
        if (iniciar && !iniciar_ant_q) begin
          estado_d     = ESPERA_VS;
          modo_d       = modo;
          lin_ini_d    = lin_ini;
          col_ini_d    = col_ini;
          incompleto_d = 1'b0;
        end else begin
          estado_d = OCIOSO;
        end
      end
      ESPERA_VS: begin
        estado_d = vsync_s ? INICIO_QUADRO : ESPERA_VS;
      end
      INICIO_QUADRO: begin
        if (vsync_desce) begin
          estado_d  = CAPTURA;
          fase_d    = 1'b0;
          col_d     = 10'd0;
          lin_d     = 10'd0;
          col_dec_d = 2'd0;
          lin_dec_d = 2'd0;
          col_arm_d = {CW{1'b0}};
          lin_arm_d = {LW{1'b0}};
          cont_d    = {AW{1'b0}};
        end else begin
          estado_d = INICIO_QUADRO;
        end
      end
      CAPTURA: begin
        if (href_desce) begin
          fase_d    = 1'b0;
          col_d     = 10'd0;
          col_dec_d = 2'd0;
          col_arm_d = {CW{1'b0}};
          lin_d     = lin_q + 10'd1;
          lin_dec_d = (lin_q >= lin_ini_q) ? proximo_dec(lin_dec_q, DEC_ULT) : lin_dec_q;
          lin_arm_d = linha_sel ? (lin_arm_q + UM_L) : lin_arm_q;
        end else if (pclk_sobe && href_s) begin
          if (fase_q == 1'b0) begin
            fase_d  = 1'b1;
            byte0_d = d_s;
          end else begin
            // Second byte completes the sensor pixel; decide now, write two clocks after the edge.
            fase_d    = 1'b0;
            col_d     = col_q + 10'd1;
            col_dec_d = (col_q >= col_ini_q) ? proximo_dec(col_dec_q, DEC_ULT) : col_dec_q;
            pix_ok_d  = linha_sel && coluna_sel;
            col_arm_d = (linha_sel && coluna_sel) ? (col_arm_q + UM_C) : col_arm_q;
            case (modo_q)
              MODO_RGB565: pix_d = {byte0_q, d_s};
              MODO_CINZA:  pix_d = {8'h00, byte0_q};
              default:     pix_d = {byte0_q, d_s};
            endcase
          end
        end else begin
          fase_d = fase_q;
        end

        if (pix_ok_q && (cont_q < TOTAL_A)) begin
          we_d   = 1'b1;
          dado_d = pix_q;
          end_d  = cont_q[S_ADDR-1:0];
          cont_d = cont_q + UM_A;
        end else begin
          we_d = 1'b0;
        end

        if (cont_q == TOTAL_A) begin
          estado_d = FIM;
        end else if (vsync_sobe) begin
          estado_d     = FIM;
          incompleto_d = 1'b1;
        end else begin
          estado_d = CAPTURA;
        end
      end
      FIM: begin
        estado_d = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase

    ocupado_d = (estado_d == ESPERA_VS) || (estado_d == INICIO_QUADRO) || (estado_d == CAPTURA);
    pronto_d  = (estado_d == FIM);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q      <= OCIOSO;
      iniciar_ant_q <= 1'b0;
      modo_q        <= 1'b0;
      lin_ini_q     <= 10'd0;
      col_ini_q     <= 10'd0;
      incompleto_q  <= 1'b0;
      fase_q        <= 1'b0;
      byte0_q       <= 8'd0;
      col_q         <= 10'd0;
      lin_q         <= 10'd0;
      col_dec_q     <= 2'd0;
      lin_dec_q     <= 2'd0;
      col_arm_q     <= {CW{1'b0}};
      lin_arm_q     <= {LW{1'b0}};
      cont_q        <= {AW{1'b0}};
      pix_ok_q      <= 1'b0;
      pix_q         <= 16'd0;
      we_q          <= 1'b0;
      end_q         <= {S_ADDR{1'b0}};
      dado_q        <= 16'd0;
      ocupado_q     <= 1'b0;
      pronto_q      <= 1'b0;
    end else begin
      estado_q      <= estado_d;
      iniciar_ant_q <= iniciar_ant_d;
      modo_q        <= modo_d;
      lin_ini_q     <= lin_ini_d;
      col_ini_q     <= col_ini_d;
      incompleto_q  <= incompleto_d;
      fase_q        <= fase_d;
      byte0_q       <= byte0_d;
      col_q         <= col_d;
      lin_q         <= lin_d;
      col_dec_q     <= col_dec_d;
      lin_dec_q     <= lin_dec_d;
      col_arm_q     <= col_arm_d;
      lin_arm_q     <= lin_arm_d;
      cont_q        <= cont_d;
      pix_ok_q      <= pix_ok_d;
      pix_q         <= pix_d;
      we_q          <= we_d;
      end_q         <= end_d;
      dado_q        <= dado_d;
      ocupado_q     <= ocupado_d;
      pronto_q      <= pronto_d;
    end
  end

  assign we         = we_q;
  assign endereco   = end_q;
  assign dado       = dado_q;
  assign ocupado    = ocupado_q;
  assign pronto     = pronto_q;
  assign incompleto = incompleto_q;
  assign db_estado  = estado_q;

endmodule

// File: tb/tb_captura_janela_ov7670.sv
// Scoreboard bench: a small camera model drives frames, a window model queues
// the expected writes, and a monitor pops and compares every write strobe.
module tb_captura_janela_ov7670;

  localparam int LINES   = 4;
  localparam int COLUMNS = 6;
  localparam int DECIM   = 2;
  localparam int S_ADDR  = 5;
  localparam int W       = 16;
  localparam int H       = 12;

  logic              clock, reset, iniciar, modo;
  logic [9:0]        lin_ini, col_ini;
  logic              VSYNC, HREF, PCLK;
  logic [7:0]        D;
  logic              we, ocupado, pronto, incompleto;
  logic [S_ADDR-1:0] endereco;
  logic [15:0]       dado;
  logic [3:0]        db_estado;

  captura_janela_ov7670 #(
    .LINES(LINES), .COLUMNS(COLUMNS), .DECIM(DECIM), .S_ADDR(S_ADDR)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .modo(modo),
    .lin_ini(lin_ini), .col_ini(col_ini), .VSYNC(VSYNC), .HREF(HREF),
    .PCLK(PCLK), .D(D), .we(we), .endereco(endereco), .dado(dado),
    .ocupado(ocupado), .pronto(pronto), .incompleto(incompleto),
    .db_estado(db_estado)
  );

  typedef struct packed {
    logic [S_ADDR-1:0] a;
    logic [15:0]       d;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] fb0 [H][W];
  logic [7:0] fb1 [H][W];
  int total = 0;
  int bad = 0;
  int pronto_cnt = 0;
  int writes_cnt = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe is matched against the head of the expected queue.
  initial begin
    wr_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (pronto) pronto_cnt++;
        if (we) begin
          writes_cnt++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got addr %0d data %h, want no write", endereco, dado);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", 32'(endereco), 32'(e.a));
            check("wr_data", 32'(dado), 32'(e.d));
          end
        end
      end
    end
  end

  // Camera: one PCLK period, HREF/VSYNC/D change while PCLK is low.
  task automatic tick(input logic h, input logic [7:0] d, input logic vs);
    PCLK = 1'b0; HREF = h; D = d; VSYNC = vs;
    #25;
    PCLK = 1'b1;
    #25;
  endtask

  task automatic vsync_pulse();
    repeat (3) tick(1'b0, 8'h00, 1'b1);
    repeat (2) tick(1'b0, 8'h00, 1'b0);
  endtask

  task automatic gen_frame(input bit a5);
    for (int h = 0; h < H; h++)
      for (int w = 0; w < W; w++) begin
        fb0[h][w] = a5 ? 8'hA5 : 8'($urandom);
        fb1[h][w] = 8'($urandom);
      end
  endtask

  task automatic send_frame();
    vsync_pulse();
    for (int h = 0; h < H; h++) begin
      for (int w = 0; w < W; w++) begin
        tick(1'b1, fb0[h][w], 1'b0);
        tick(1'b1, fb1[h][w], 1'b0);
      end
      repeat (4) tick(1'b0, 8'h00, 1'b0);
    end
    repeat (2) tick(1'b0, 8'h00, 1'b0);
  endtask

  // Window model: kept pixel (r,c) sits at sensor (li+DECIM*r, ci+DECIM*c), stored in order.
  task automatic push_expected(input int li, input int ci, input bit m, output int n);
    wr_t e;
    int ln, cl;
    n = 0;
    for (int r = 0; r < LINES; r++) begin
      ln = li + DECIM * r;
      if (ln < H) begin
        for (int c = 0; c < COLUMNS; c++) begin
          cl = ci + DECIM * c;
          if (cl < W) begin
            e.a = S_ADDR'(n);
            e.d = m ? {8'h00, fb0[ln][cl]} : {fb0[ln][cl], fb1[ln][cl]};
            exp_q.push_back(e);
            n++;
          end
        end
      end
    end
  endtask

  task automatic pulse_iniciar();
    @(negedge clock); iniciar = 1'b1;
    repeat (2) @(negedge clock);
    iniciar = 1'b0;
    @(negedge clock);
  endtask

  task automatic run_capture(input int li, input int ci, input bit m, input bit a5, input string tag);
    int n, p0;
    lin_ini = 10'(li); col_ini = 10'(ci); modo = m;
    p0 = pronto_cnt;
    pulse_iniciar();
    check({tag, "_ocupado"}, 32'(ocupado), 32'd1);
    check({tag, "_inc_clr"}, 32'(incompleto), 32'd0);
    lin_ini = 10'($urandom); col_ini = 10'($urandom); modo = ~m;
    gen_frame(a5);
    push_expected(li, ci, m, n);
    send_frame();
    vsync_pulse();
    repeat (20) @(negedge clock);
    check({tag, "_pronto"}, 32'(pronto_cnt - p0), 32'd1);
    check({tag, "_incompleto"}, 32'(incompleto), 32'(n < LINES * COLUMNS));
    check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_idle"}, 32'(ocupado), 32'd0);
  endtask

  initial begin
    int n, p0, w0;
    reset = 1'b1; iniciar = 1'b0; modo = 1'b0; lin_ini = 10'd0; col_ini = 10'd0;
    VSYNC = 1'b0; HREF = 1'b0; PCLK = 1'b0; D = 8'h00;
    repeat (3) @(negedge clock);
    check("rst_we", 32'(we), 32'd0);
    check("rst_end", 32'(endereco), 32'd0);
    check("rst_dado", 32'(dado), 32'd0);
    check("rst_ocupado", 32'(ocupado), 32'd0);
    check("rst_pronto", 32'(pronto), 32'd0);
    check("rst_incompleto", 32'(incompleto), 32'd0);
    check("rst_estado", 32'(db_estado), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("idle_estado", 32'(db_estado), 32'd0);

    run_capture(0, 0, 1'b0, 1'b0, "full_rgb");
    run_capture(1, 3, 1'b1, 1'b1, "gray_a5");
    run_capture(8, 0, 1'b0, 1'b0, "short_frame");
    for (int k = 0; k < 3; k++)
      run_capture($urandom_range(0, H - 1), $urandom_range(0, W - 1),
                  1'($urandom_range(0, 1)), 1'b0, "random");

    // iniciar during an active frame: that frame must be skipped entirely.
    lin_ini = 10'd0; col_ini = 10'd2; modo = 1'b0;
    gen_frame(1'b0);
    p0 = pronto_cnt; w0 = writes_cnt;
    fork
      send_frame();
      begin
        repeat (200) @(negedge clock);
        pulse_iniciar();
        check("mid_ocupado", 32'(ocupado), 32'd1);
        lin_ini = 10'd5; col_ini = 10'd0; modo = 1'b1;
        repeat (100) @(negedge clock);
        pulse_iniciar();
        check("mid_estado", 32'(db_estado), 32'd1);
      end
    join
    check("mid_no_early_write", 32'(writes_cnt - w0), 32'd0);
    gen_frame(1'b0);
    push_expected(0, 2, 1'b0, n);
    send_frame();
    vsync_pulse();
    repeat (20) @(negedge clock);
    check("mid_pronto", 32'(pronto_cnt - p0), 32'd1);
    check("mid_drain", 32'(exp_q.size()), 32'd0);
    check("mid_incompleto", 32'(incompleto), 32'(n < LINES * COLUMNS));

    // Reset in the middle of a capture.
    lin_ini = 10'd0; col_ini = 10'd0; modo = 1'b0;
    pulse_iniciar();
    gen_frame(1'b0);
    push_expected(0, 0, 1'b0, n);
    p0 = pronto_cnt; w0 = writes_cnt;
    fork
      send_frame();
      begin
        for (int i = 0; i < 20000 && writes_cnt < w0 + 10; i++) @(negedge clock);
        check("rst_mid_reached", 32'(writes_cnt - w0), 32'd10);
        reset = 1'b1;
        #1;
        check("rst_mid_we", 32'(we), 32'd0);
        check("rst_mid_end", 32'(endereco), 32'd0);
        check("rst_mid_dado", 32'(dado), 32'd0);
        check("rst_mid_ocupado", 32'(ocupado), 32'd0);
        check("rst_mid_pronto", 32'(pronto), 32'd0);
        check("rst_mid_estado", 32'(db_estado), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clock);
        reset = 1'b0;
      end
    join
    vsync_pulse();
    repeat (20) @(negedge clock);
    check("rst_mid_no_pronto", 32'(pronto_cnt - p0), 32'd0);
    check("rst_mid_no_write", 32'(writes_cnt - w0), 32'd10);
    check("rst_mid_incompleto", 32'(incompleto), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout, want test end");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/captura_janela_ov7670.md
CAPTURA_JANELA_OV7670 -- requirements
Module: captura_janela_ov7670

Interface
REQ-001 SHALL have parameter LINES, default 120: stored lines per frame.
REQ-002 SHALL have parameter COLUMNS, default 160: stored pixels per stored line.
REQ-003 SHALL have parameter DECIM, default 2: keep 1 of every DECIM sensor lines and 1 of every DECIM sensor pixels (1..4).
REQ-004 SHALL have parameter S_ADDR, default 15: address width, with 2^S_ADDR >= LINES*COLUMNS.
REQ-005 SHALL have these ports:
- clock  in  1: system clock; the only clock.
- reset  in  1: asynchronous, active-high reset.
- iniciar  in  1: capture request; acted on at its rising edge.
- modo  in  1: 0 = RGB565 (2 bytes per pixel); 1 = gray (Y byte of YUYV).
- lin_ini  in  10: first sensor line of the window.
- col_ini  in  10: first sensor pixel of the window.
- VSYNC, HREF, PCLK  in  1 each: camera timing, asynchronous to clock.
- D  in  8: camera data.
- we  out  1: one-cycle write strobe.
- endereco  out  S_ADDR: write address.
- dado  out  16: pixel to write.
- ocupado  out  1: capture in progress.
- pronto  out  1: one-cycle end-of-capture pulse.
- incompleto  out  1: sticky frame-short flag.
- db_estado  out  4: current state code.

Function
REQ-006 SHALL pass VSYNC, HREF, PCLK and D through 2-flop synchronizers; a PCLK rising edge is detected from synchronized samples and the synchronized D byte is taken in that cycle; clock SHALL be at least 4x PCLK.
REQ-007 SHALL implement FSM OCIOSO(0) -> ESPERA_VS(1) -> INICIO_QUADRO(2) -> CAPTURA(3) -> FIM(4) -> OCIOSO.
REQ-008 OCIOSO SHALL move to ESPERA_VS on the rising edge of iniciar; iniciar edges in any other state SHALL be ignored.
REQ-009 ESPERA_VS SHALL wait for synchronized VSYNC high; INICIO_QUADRO SHALL wait for VSYNC falling, then clear all counters and enter CAPTURA; a partial frame SHALL never be captured.
REQ-010 In CAPTURA, each PCLK edge with HREF high SHALL toggle a byte phase (0 then 1).
- modo=0: pixel = {byte0,byte1}.
- modo=1: pixel = {8'h00,byte0}.
- A sensor pixel completes at phase 1.
REQ-011 Sensor column counter (10 b) SHALL count completed pixels and clear on HREF falling; sensor line counter (10 b) SHALL increment on HREF falling.
REQ-012 A completed pixel SHALL be stored only if all of the following hold:
- line >= lin_ini, and (line - lin_ini) mod DECIM = 0, and fewer than LINES lines have been stored;
- column >= col_ini, and (column - col_ini) mod DECIM = 0, and fewer than COLUMNS pixels have been stored in this line.
Modulo SHALL use decimation counters, not a divider.
REQ-013 Store SHALL be: we=1 for exactly one cycle, 2 clocks after the detected PCLK edge, with dado and endereco valid in that cycle; endereco starts at 0 and increments by 1 per store, row-major.
REQ-014 When the store count reaches LINES*COLUMNS, SHALL enter FIM on the next cycle; no further we SHALL be issued.
REQ-015 VSYNC rising while in CAPTURA with fewer stores SHALL enter FIM and set incompleto=1; incompleto SHALL clear only on the next accepted iniciar.
REQ-016 FIM SHALL assert pronto for 1 cycle, then return to OCIOSO.
REQ-017 ocupado SHALL be 1 in states 1-3 and 0 otherwise.
REQ-018 lin_ini, col_ini and modo SHALL be latched at the accepted iniciar; changes during capture SHALL have no effect.
REQ-019 A window exceeding the sensor frame SHALL not hang the block: it ends through REQ-015.

Reset
REQ-020 On reset the block SHALL go to OCIOSO with we=0, endereco=0, dado=0, ocupado=0, pronto=0, incompleto=0, db_estado=0, and all counters and synchronizers cleared.
REQ-021 Reset asserted mid-capture SHALL abort immediately, with no pronto and no further we.

Structure
REQ-022 State codes and the modo encodings SHALL live in the shared package ov7670_pkg.
REQ-023 One sub-module is natural: sincronizador_ov7670 (2-flop synchronizers plus PCLK, HREF and VSYNC edge pulses); the FSM and counters stay in captura_janela_ov7670.

Verification
REQ-024 Camera model 640x480, DECIM=2, LINES=120, COLUMNS=160, lin_ini=col_ini=0, modo=0 -> 19200 writes, addresses 0..19199 contiguous, dado[k] = the model pixel at (2*(k/160), 2*(k%160)), one pronto, incompleto=0.
REQ-025 modo=1 with YUYV bytes Y=8'hA5 -> every dado = 16'h00A5.
REQ-026 lin_ini=400, LINES=120 on a 480-line frame -> 40*160 writes, incompleto=1, pronto once.
REQ-027 iniciar pulsed mid-frame (VSYNC low) -> first write only after the next VSYNC high then low; a second iniciar while ocupado is ignored.
REQ-028 reset asserted after 500 writes -> we=0 from the next cycle, all outputs at reset values, no pronto.
